// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and reserve signals of the dual-write register file
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [DATA_W-1:0] bus_a;
    logic [DATA_W-1:0] bus_b;
    logic [ADDR_W-1:0] rw0;
    logic [DATA_W-1:0] bus_w0;
    logic              reg_wr0;
    logic [ADDR_W-1:0] rw1;
    logic [DATA_W-1:0] bus_w1;
    logic              reg_wr1;
    logic              rsv;
    logic [ADDR_W-1:0] rsv_addr;
    logic              busy_a;
    logic              busy_b;

    modport master (
        output ra, rb, rw0, bus_w0, reg_wr0, rw1, bus_w1, reg_wr1, rsv, rsv_addr,
        input  bus_a, bus_b, busy_a, busy_b
    );

    modport slave (
        input  ra, rb, rw0, bus_w0, reg_wr0, rw1, bus_w1, reg_wr1, rsv, rsv_addr,
        output bus_a, bus_b, busy_a, busy_b
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2-read/2-write register file with optional bypass, zero register and busy scoreboard
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              we0, we1, fwd;

    assign we0 = bus.reg_wr0 && !(ZERO_REG != 0 && bus.rw0 == '0);
    assign we1 = bus.reg_wr1 && !(ZERO_REG != 0 && bus.rw1 == '0);
    assign fwd = BYPASS != 0 && !rst;

    always_comb begin
        busy_d = busy_q;
        if (we0) busy_d[bus.rw0] = 1'b0;
        if (we1) busy_d[bus.rw1] = 1'b0;
        if (bus.rsv && !(ZERO_REG != 0 && bus.rsv_addr == '0)) busy_d[bus.rsv_addr] = 1'b1;
    end

    // port 1 is written last so it wins an address collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            if (we0) regs_q[bus.rw0] <= bus.bus_w0;
            if (we1) regs_q[bus.rw1] <= bus.bus_w1;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        bus.bus_a = (ZERO_REG != 0 && bus.ra == '0) ? '0 :
                    (fwd && bus.reg_wr1 && bus.rw1 == bus.ra) ? bus.bus_w1 :
                    (fwd && bus.reg_wr0 && bus.rw0 == bus.ra) ? bus.bus_w0 : regs_q[bus.ra];
        bus.bus_b = (ZERO_REG != 0 && bus.rb == '0) ? '0 :
                    (fwd && bus.reg_wr1 && bus.rw1 == bus.rb) ? bus.bus_w1 :
                    (fwd && bus.reg_wr0 && bus.rw0 == bus.rb) ? bus.bus_w0 : regs_q[bus.rb];
    end

    assign bus.busy_a = busy_q[bus.ra];
    assign bus.busy_b = busy_q[bus.rb];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp with directed vectors and a random regression
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus();
    regfile_mp dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       nm;
        logic [31:0] a;
        logic [31:0] b;
        logic        ba;
        logic        bb;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] m_reg [32];
    logic [31:0] m_busy;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.nm, ".bus_a"}, bus.bus_a, e.a);
            check({e.nm, ".bus_b"}, bus.bus_b, e.b);
            check({e.nm, ".busy_a"}, 32'(bus.busy_a), 32'(e.ba));
            check({e.nm, ".busy_b"}, 32'(bus.busy_b), 32'(e.bb));
        end
    end

    task automatic drive(input logic [4:0] ra, input logic [4:0] rb,
                         input logic we0, input logic [4:0] rw0, input logic [31:0] w0,
                         input logic we1, input logic [4:0] rw1, input logic [31:0] w1,
                         input logic rsv, input logic [4:0] rsv_addr);
        bus.ra = ra; bus.rb = rb;
        bus.reg_wr0 = we0; bus.rw0 = rw0; bus.bus_w0 = w0;
        bus.reg_wr1 = we1; bus.rw1 = rw1; bus.bus_w1 = w1;
        bus.rsv = rsv; bus.rsv_addr = rsv_addr;
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (!rst && bus.reg_wr1 && bus.rw1 == a) return bus.bus_w1;
        if (!rst && bus.reg_wr0 && bus.rw0 == a) return bus.bus_w0;
        return m_reg[a];
    endfunction

    task automatic advance();
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = '0;
            m_busy = '0;
        end else begin
            if (bus.reg_wr0 && bus.rw0 != 0) begin m_reg[bus.rw0] = bus.bus_w0; m_busy[bus.rw0] = 1'b0; end
            if (bus.reg_wr1 && bus.rw1 != 0) begin m_reg[bus.rw1] = bus.bus_w1; m_busy[bus.rw1] = 1'b0; end
            if (bus.rsv && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic ba, input logic bb);
        exp_t e;
        e.nm = nm; e.a = a; e.b = b; e.ba = ba; e.bb = bb;
        q.push_back(e);
        advance();
    endtask

    task automatic mdl(input string nm);
        vec(nm, m_rd(bus.ra), m_rd(bus.rb), m_busy[bus.ra], m_busy[bus.rb]);
    endtask

    function automatic logic [4:0] raddr();
        return 5'($urandom_range(1) != 0 ? $urandom_range(7) : $urandom_range(31));
    endfunction

    task automatic rnd_inputs();
        drive(raddr(), raddr(), 1'($urandom_range(1)), raddr(), $urandom,
              1'($urandom_range(1)), raddr(), $urandom, 1'($urandom_range(1)), raddr());
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rnd_inputs();
            mdl("pre_rand");
        end
        drive(3, 3, 1, 3, 32'h12345678, 0, 0, 0, 0, 0);
        mdl("wr3");
        rst = 1'b1;
        drive(3, 3, 1, 3, 32'hAAAAAAAA, 0, 0, 0, 1, 3);
        vec("rst_nobyp", 32'h12345678, 32'h12345678, 1'b0, 1'b0);
        rst = 1'b0;
        drive(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("rst_clear", 32'h0, 32'h0, 1'b0, 1'b0);
        drive(5, 5, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        vec("byp5", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
        drive(5, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("rd5", 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        drive(7, 5, 1, 7, 32'h1111, 1, 7, 32'h2222, 0, 0);
        vec("coll_byp", 32'h2222, 32'hDEADBEEF, 1'b0, 1'b0);
        drive(7, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("coll_rd", 32'h2222, 32'h2222, 1'b0, 1'b0);
        drive(0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0);
        vec("zero_byp", 32'h0, 32'h0, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("zero_rd", 32'h0, 32'h0, 1'b0, 1'b0);
        drive(9, 5, 0, 0, 0, 0, 0, 0, 1, 9);
        vec("rsv9", 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        drive(9, 9, 0, 0, 0, 1, 9, 32'h99, 0, 0);
        vec("wr9_busy", 32'h99, 32'h99, 1'b1, 1'b1);
        drive(9, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("wr9_clear", 32'h99, 32'h99, 1'b0, 1'b0);
        drive(9, 9, 1, 9, 32'h77, 0, 0, 0, 1, 9);
        vec("rsv_wr9", 32'h77, 32'h77, 1'b0, 1'b0);
        drive(9, 9, 0, 0, 0, 0, 0, 0, 1, 9);
        vec("rsv_wins", 32'h77, 32'h77, 1'b1, 1'b1);
        drive(9, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("rsv_again", 32'h77, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5000; i++) begin
            rst = ($urandom_range(9) == 0);
            rnd_inputs();
            mdl("rand");
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
